// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative multiply/divide sequencer for the MIPS HI/LO unit.
//
// Executes MULTU (op=00), MULT (01), DIVU (10) and DIV (11). Every arithmetic
// step goes through a single shared 32-bit ripple adder (somador32bits),
// one pass per cycle. Subtraction is done as x + ~y + 1.
//
// Sequence: IDLE -> NEG_A -> NEG_B -> RUN (32 cycles) -> NEG_LO -> NEG_HI
//           -> DONE -> IDLE. done is high in the cycle after edge k+36,
//           where k is the accepting edge.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; accepted only while busy=0 (IDLE or DONE)
//   op[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a[31:0]      multiplicand / dividend (rs)
//   b[31:0]      multiplier / divisor (rt)
//   busy         high while an operation is in progress
//   done         one-cycle pulse when hi/lo are valid
//   hi[31:0]     product[63:32] / remainder
//   lo[31:0]     product[31:0]  / quotient
//   div_by_zero  set with done for DIV/DIVU when b==0; held until next start
//
// Optional feature: define MULDIV_ZERO_BYPASS_EN to skip the iterative path
// for a multiply with a zero operand or a divide by zero (done after k+1).

module somador32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [32:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 32; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[32];
    end

endmodule

module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_RUN,
        S_NEG_LO,
        S_NEG_HI,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high / partial remainder
    logic [WIDTH-1:0] low_q, low_d;     // multiplier / quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;   // |b|: multiplicand / divisor
    logic [4:0]       cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
`ifdef MULDIV_ZERO_BYPASS_EN
    logic             byp_q, byp_d;
`endif

    // Shared adder
    logic [31:0] add_a, add_b, add_s;
    logic        add_cin, add_cout;

    somador32bits u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    // Operation decode on the latched request
    logic is_div, sgn_a, sgn_b, dbz_op, neg_lo, neg_hi, accept;
    logic [WIDTH-1:0] rem_sh, quo_sh;

    assign is_div = op_q[1];
    assign sgn_a  = op_q[0] & a_q[WIDTH-1];
    assign sgn_b  = op_q[0] & b_q[WIDTH-1];
    assign dbz_op = is_div & (b_q == '0);
    assign neg_lo = (sgn_a ^ sgn_b) & ~dbz_op;
    // Multiply negates the full 64-bit product; DIV's remainder follows the dividend.
    assign neg_hi = is_div ? (sgn_a & ~dbz_op) : (sgn_a ^ sgn_b);
    assign accept = start & ~busy;
    assign rem_sh = {acc_q[WIDTH-2:0], low_q[WIDTH-1]};
    assign quo_sh = {low_q[WIDTH-2:0], 1'b0};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_NEG_A;
`ifdef MULDIV_ZERO_BYPASS_EN
            S_NEG_A:  state_d = byp_q ? S_DONE : S_NEG_B;
`else
            S_NEG_A:  state_d = S_NEG_B;
`endif
            S_NEG_B:  state_d = S_RUN;
            S_RUN:    if (cnt_q == 5'd31) state_d = S_NEG_LO;
            S_NEG_LO: state_d = S_NEG_HI;
            S_NEG_HI: state_d = S_DONE;
            S_DONE:   state_d = accept ? S_NEG_A : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_IDLE:  ;
            S_DONE:  done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Datapath: one adder pass per cycle, operands selected by state
    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
`ifdef MULDIV_ZERO_BYPASS_EN
        byp_d   = byp_q;
`endif
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    low_d   = '0;
                    opnd_d  = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    dbz_d   = 1'b0;
`ifdef MULDIV_ZERO_BYPASS_EN
                    byp_d   = op[1] ? (b == '0) : ((a == '0) | (b == '0));
`endif
                end
            end

            S_NEG_A: begin
                add_a   = sgn_a ? ~a_q : a_q;
                add_cin = sgn_a;
                low_d   = add_s;
`ifdef MULDIV_ZERO_BYPASS_EN
                if (byp_q) begin
                    hi_d  = is_div ? a_q : '0;
                    lo_d  = is_div ? '1 : '0;
                    dbz_d = is_div;
                end
`endif
            end

            S_NEG_B: begin
                add_a   = sgn_b ? ~b_q : b_q;
                add_cin = sgn_b;
                opnd_d  = add_s;
                cnt_d   = '0;
            end

            S_RUN: begin
                if (is_div) begin
                    add_a   = rem_sh;
                    add_b   = ~opnd_q;
                    add_cin = 1'b1;
                    // The bit shifted out of acc is the 33rd remainder bit; when
                    // set, the subtraction always fits and the 32-bit sum is exact.
                    if (add_cout | acc_q[WIDTH-1]) begin
                        acc_d = add_s;
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh;
                        low_d = quo_sh;
                    end
                end else begin
                    add_a = acc_q;
                    add_b = low_q[0] ? opnd_q : '0;
                    acc_d = {add_cout, add_s[WIDTH-1:1]};
                    low_d = {add_s[0], low_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
            end

            S_NEG_LO: begin
                add_a   = neg_lo ? ~low_q : low_q;
                add_cin = neg_lo;
                low_d   = add_s;
                carry_d = add_cout;
            end

            S_NEG_HI: begin
                if (neg_hi) begin
                    add_a   = ~acc_q;
                    add_cin = is_div ? 1'b1 : carry_q;
                end else begin
                    add_a   = acc_q;
                end
                hi_d  = dbz_op ? a_q : add_s;
                lo_d  = dbz_op ? '1 : low_q;
                dbz_d = dbz_op;
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
`ifdef MULDIV_ZERO_BYPASS_EN
            byp_q   <= 1'b0;
`endif
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
`ifdef MULDIV_ZERO_BYPASS_EN
            byp_q   <= byp_d;
`endif
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq. Expected values are hand-computed.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

`ifdef MULDIV_ZERO_BYPASS_EN
    localparam int BYP_LAT = 1;
`else
    localparam int BYP_LAT = 36;
`endif

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request before edge k; returns just after edge k with inputs scrambled.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
    endtask

    // lat = number of edges after k at which done is first seen (bounded).
    task automatic wait_done(output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        @(negedge clk);
        while (done !== 1'b1 && lat < 80) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int busy_bad,
                                input int exp_lat, input logic [31:0] ehi,
                                input logic [31:0] elo, input logic edbz);
        check_val({tag, ".lat"},  32'(lat), 32'(exp_lat));
        check_val({tag, ".busy_run"}, 32'(busy_bad), 32'd0);
        check_val({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        check_val({tag, ".hi"},  hi, ehi);
        check_val({tag, ".lo"},  lo, elo);
        check_val({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_lat, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edbz);
        int lat, bb;
        issue(o, x, y);
        wait_done(lat, bb);
        check_result(tag, lat, bb, exp_lat, ehi, elo, edbz);
        @(negedge clk);
        check_val({tag, ".pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat, bb, first_done, n_done;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        check_val("rst.busy", {31'd0, busy}, 32'd0);
        check_val("rst.done", {31'd0, done}, 32'd0);
        check_val("rst.hi", hi, 32'd0);
        check_val("rst.lo", lo, 32'd0);
        check_val("rst.dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 36, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_n3x7", 2'b01, 32'hFFFFFFFD, 32'd7,        36, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("mult_n2xn3",2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 36, 32'h00000000, 32'h00000006, 1'b0);
        run_op("div_n7d2",  2'b11, 32'hFFFFFFF9, 32'd2,        36, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_7dn2",  2'b11, 32'd7,        32'hFFFFFFFE, 36, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("divu_100d7",2'b10, 32'd100,      32'd7,        36, 32'd2,        32'd14,       1'b0);
        run_op("divu_big",  2'b10, 32'hFFFFFFFF, 32'h80000001, 36, 32'h7FFFFFFE, 32'h00000001, 1'b0);
        run_op("divu_5d0",  2'b10, 32'd5,        32'd0,   BYP_LAT, 32'd5,        32'hFFFFFFFF, 1'b1);
        run_op("mult_0x9",  2'b01, 32'd0,        32'd9,   BYP_LAT, 32'd0,        32'd0,        1'b0);

        // DIV overflow case, then a new request accepted during its DONE cycle
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bb);
        check_result("div_min", lat, bb, 36, 32'h00000000, 32'h80000000, 1'b0);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        wait_done(lat, bb);
        check_result("b2b", lat, bb, 36, 32'd2, 32'd14, 1'b0);

        // A start while busy (edge k+5) must be ignored
        issue(2'b00, 32'd3, 32'd5);
        first_done = -1;
        n_done     = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (n == 4) begin
                start = 1'b1;
                op    = 2'b10;
                a     = 32'd100;
                b     = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = n;
                    check_val("ign.hi", hi, 32'd0);
                    check_val("ign.lo", lo, 32'd15);
                end
            end
        end
        check_val("ign.lat", 32'(first_done), 32'd36);
        check_val("ign.ndone", 32'(n_done), 32'd1);

        // Reset in flight: outputs clear at once, no done afterwards
        issue(2'b01, 32'd11, 32'd13);
        for (int n = 0; n < 10; n++) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mrst.busy", {31'd0, busy}, 32'd0);
        check_val("mrst.done", {31'd0, done}, 32'd0);
        check_val("mrst.hi", hi, 32'd0);
        check_val("mrst.lo", lo, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        bb     = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) bb++;
        end
        check_val("mrst.ndone", 32'(n_done), 32'd0);
        check_val("mrst.nbusy", 32'(bb), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS HI/LO unit. Executes MULT, MULTU, DIV and DIVU.
- All arithmetic goes through one instance of the 32-bit ripple adder (somador32bits), one pass per cycle. Subtraction uses inverted operand with cin=1.
- Sits beside the main ALU. The execute stage starts it and stalls on busy.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported because the shared adder is fixed at 32 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  32  multiplicand / dividend (rs)
- b  in  32  multiplier / divisor (rt)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when hi/lo are valid
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- div_by_zero  out  1  set with done for DIV/DIVU when b==0; held until next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0. All working registers cleared. An operation in flight is abandoned with no done.
- States: IDLE -> NEG_A -> NEG_B -> RUN(32 cycles) -> NEG_LO -> NEG_HI -> DONE -> IDLE.
- Acceptance: start=1 and busy=0 at edge k. a, b and op are latched. busy=1 from edge k. Inputs after edge k are ignored. start while busy=1 is ignored with no queueing.
- NEG_A / NEG_B (signed ops only): the adder forms the magnitude of a, then b (~x + 1) if negative. Unsigned ops, or non-negative operands, pass the value unchanged through the adder (x + 0). Cycle count is the same either way.
- RUN, multiply: shift-add over 64-bit {acc, mplr}. Each cycle: if mplr[0], acc+mcand via the adder. Then shift right 1, taking cout into acc[31].
- RUN, divide: restoring division over {rem, quo}. Each cycle: shift left 1, then rem - divisor via the adder (cin=1). If cout=1, keep the difference and set quo[0]=1. Otherwise restore.
- NEG_LO: if the result must be negated, lo = ~lo + 1, and the carry out is captured. Multiply negates when sign(a)^sign(b). DIV negates the quotient when sign(a)^sign(b).
- NEG_HI: multiply uses hi = ~hi + captured carry, a 64-bit two's-complement negate. DIV negates the remainder independently (cin=1) when sign(a)=1.
- DONE: hi/lo/div_by_zero outputs update at the edge entering DONE. done=1 and busy=0 for exactly that cycle.
- Latency: done is high in the cycle after edge k+36, for every op and operand.
- Back-to-back: start may be asserted during the DONE cycle and is accepted at that edge.
- Divide by zero (b==0, DIV or DIVU): hi=a (raw), lo=32'hFFFFFFFF, div_by_zero=1. No sign correction is applied. Latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps), div_by_zero=0.
- hi/lo hold their last result between operations and during busy.

Optional Feature:
- Macro: MULDIV_ZERO_BYPASS_EN.
- When defined, the block skips the iterative path if, at acceptance:
  - op is a multiply and a==0 or b==0; or
  - op is a divide and b==0.
- In that case it goes IDLE -> DONE directly, with done high in the cycle after edge k+1. Results: hi=lo=0 for a multiply; the divide-by-zero values above for a divide.
- When undefined, all operations take the fixed 36-cycle path. No zero detection logic is present.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done after edge k+36, hi=0xFFFFFFFE, lo=0x00000001; busy high edges k..k+35.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> div_by_zero=1, hi=5, lo=0xFFFFFFFF. With MULDIV_ZERO_BYPASS_EN: done after edge k+1. MULT a=0, b=9 with the macro -> hi=lo=0 after edge k+1.
- Second start at k+5 is ignored (no extra done). Assert rst at k+10 -> busy=0, done=0, hi=lo=0 immediately; no done follows.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. New start during DONE cycle -> accepted, next done 36 cycles later.
